led_pattern_seq: RTL and testbench
==================================

// Module: led_pattern_seq
// PURPOSE
//  Upstream source of the board LED demo. Generates the 6-bit LED pattern and free-running
//  step counter that drive the Tang Nano 9K LEDs; clk, leds and clockCounter are the nets
//  tapped by the on-chip logic-analyzer probe. A debounced push button cycles pattern modes.
// PARAMETERS
//  STEP_TICKS      13_500_000  clk cycles per pattern step (0.5 s @ 27 MHz); must be >= 2
//  DEBOUNCE_TICKS  270_000     cycles button must be stable before accepted (10 ms)
//  CNT_W           24          clockCounter width; 2**CNT_W > STEP_TICKS
//  LED_W           6           number of LEDs
//  LED_ACTIVE_LOW  1           1: leds = ~pattern (board LEDs sink current)
// PORTS
//  clk           in   1      system clock, 27 MHz
//  rst           in   1      asynchronous, active-high reset
//  btn_n         in   1      raw mode button, active low, asynchronous to clk
//  btn2_n        in   1      raw pause button, active low (only with LED_PAUSE_EN)
//  leds          out  LED_W  registered LED drive, polarity per LED_ACTIVE_LOW
//  clockCounter  out  CNT_W  step prescaler value, probe visibility
//  mode          out  2      current mode (SHIFT=0, BOUNCE=1, BINARY=2), probe visibility
// BEHAVIOUR
//  - Reset: clockCounter=0, mode=SHIFT, pattern=000001, dir=left, leds=111110 (active low).
//  - clockCounter increments each clk; at STEP_TICKS-1 wraps to 0 and asserts internal
//    step pulse for that cycle. Pattern updates on the cycle after step; leds one cycle later.
//  - Button path: 2-flop synchronizer -> stability counter; level accepted after
//    DEBOUNCE_TICKS consecutive equal samples; press = accepted 1->0 transition, 1-cycle pulse.
//    Glitches shorter than DEBOUNCE_TICKS never produce a press. Holding gives one press only.
//  - Mode FSM on press: SHIFT -> BOUNCE -> BINARY -> SHIFT (code 3 unreachable; decode to SHIFT).
//  - On mode change: pattern loads mode init (SHIFT/BOUNCE 000001, BINARY 000000), dir=left,
//    clockCounter cleared to 0. Press and step in same cycle: press wins, step dropped.
//  - SHIFT: rotate left, 100000 -> 000001.
//  - BOUNCE: shift in dir; at 100000 dir flips right, at 000001 flips left; endpoints shown
//    once (…010000,100000,010000…). Sequence period 2*(LED_W-1) steps.
//  - BINARY: pattern+1 modulo 2**LED_W, 111111 -> 000000.
//  - rst asserted mid-operation: all state returns to reset values immediately (async),
//    debounce counters cleared, button considered released; release is synchronous to clk.
// CONFIGURATION
//  LED_PAUSE_EN defined: btn2_n gets its own synchronizer+debouncer; each press toggles
//    paused (reset 0). While paused clockCounter and pattern hold, mode button still works
//    (mode change loads init and clears counter, stays paused).
//  LED_PAUSE_EN undefined: btn2_n port absent, never paused; no pause logic synthesized.
// STRUCTURE
//  led_seq_pkg: mode_e enum {MODE_SHIFT, MODE_BOUNCE, MODE_BINARY}, init pattern constants,
//    mode_next() function.
//  Sub-module btn_debounce (params DEBOUNCE_TICKS; ports clk, rst, btn_n, level, press),
//    instantiated once for btn_n and once for btn2_n under LED_PAUSE_EN.
//  Top: prescaler, mode FSM, pattern datapath, output register.
// TESTING  (bench uses STEP_TICKS=4, DEBOUNCE_TICKS=3)
//  1 Reset: rst high 5 cycles -> leds=111110, clockCounter=0, mode=0; release -> counter 0,1,2,3,0.
//  2 SHIFT: run 7 steps -> pattern 000010..100000 then 000001 (leds inverted), one change per 4 clks.
//  3 Debounce: btn_n low 2 cycles -> no mode change; low 10 cycles -> exactly one press, mode=1,
//    counter=0, pattern=000001; held low 100 cycles -> no further change.
//  4 BOUNCE: 12 steps -> 000010,000100,001000,010000,100000,010000,...,000001,000010,000100.
//  5 BINARY + collision: enter mode 2, run 64 steps -> wraps 111111->000000; press landing on
//    the step cycle -> mode=0, pattern=000001, counter=0, no extra step.
//  6 Reset mid-op: rst pulse during BOUNCE while btn_n low -> reset values, no press after release;
//    with LED_PAUSE_EN: btn2_n press -> counter frozen 20 cycles, second press resumes.

Source files
------------

// File: rtl/led_pattern_seq_pkg.sv
// rtl/led_pattern_seq_pkg.sv - mode/direction types, init patterns and mode sequencing for led_pattern_seq
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINARY = 2'd2
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int SHIFT_INIT  = 1;
  localparam int BOUNCE_INIT = 1;
  localparam int BINARY_INIT = 0;

  // Encoding 3 is unreachable; it decodes to SHIFT like the wrap from BINARY.
  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_SHIFT:  return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_BINARY;
      default:     return MODE_SHIFT;
    endcase
  endfunction

  function automatic int mode_init(input mode_e m);
    case (m)
      MODE_BOUNCE: return BOUNCE_INIT;
      MODE_BINARY: return BINARY_INIT;
      default:     return SHIFT_INIT;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// rtl/led_pattern_seq_if.sv - button inputs and LED/probe outputs of led_pattern_seq
// Signals: btn_n (mode button, active low), btn2_n (pause button, only with LED_PAUSE_EN),
//          leds, clockCounter, mode.
// master: the sequencer side; slave: the board / bench side.
interface led_pattern_seq_if #(
  parameter int LED_W = 6,
  parameter int CNT_W = 24
);
  logic             btn_n;
`ifdef LED_PAUSE_EN
  logic             btn2_n;
`endif
  logic [LED_W-1:0] leds;
  logic [CNT_W-1:0] clockCounter;
  logic [1:0]       mode;

`ifdef LED_PAUSE_EN
  modport master (input btn_n, input btn2_n, output leds, output clockCounter, output mode);
  modport slave  (output btn_n, output btn2_n, input leds, input clockCounter, input mode);
`else
  modport master (input btn_n, output leds, output clockCounter, output mode);
  modport slave  (output btn_n, input leds, input clockCounter, input mode);
`endif
endinterface

// File: rtl/led_pattern_seq_btn_debounce.sv
// rtl/led_pattern_seq_btn_debounce.sv - btn_debounce: 2-flop synchronizer plus stability counter for an active-low button
// Ports: clk, rst (async, active high), btn_n (raw, asynchronous),
//        level (accepted debounced level, 1 = released), press (1-cycle pulse on accepted 1->0).
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 270_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);
  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that differ from the accepted level;
  // any sample equal to the accepted level restarts the count, so short glitches die here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED demo sequencer: step prescaler, mode FSM, pattern datapath, LED register
// Ports: clk, rst (async, active high), bus (led_pattern_seq_if.master: btn_n, [btn2_n], leds,
//        clockCounter, mode). Optional pause button and pause logic under macro LED_PAUSE_EN.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int STEP_TICKS     = 13_500_000,
  parameter int DEBOUNCE_TICKS = 270_000,
  parameter int CNT_W          = 24,
  parameter int LED_W          = 6,
  parameter int LED_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  led_pattern_seq_if.master bus
);
  localparam logic [LED_W-1:0] RESET_PAT  = LED_W'(SHIFT_INIT);
  localparam logic [LED_W-1:0] RESET_LEDS = (LED_ACTIVE_LOW != 0) ? ~RESET_PAT : RESET_PAT;
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);

  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] pat_q, pat_d, leds_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step, mode_press, run;
  logic             mode_level_unused;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.btn_n),
    .level (mode_level_unused),
    .press (mode_press)
  );

`ifdef LED_PAUSE_EN
  logic pause_press, paused_q, pause_level_unused;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_pause_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.btn2_n),
    .level (pause_level_unused),
    .press (pause_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) paused_q <= 1'b0;
    else     paused_q <= paused_q ^ pause_press;
  end

  assign run = ~paused_q;
`else
  assign run = 1'b1;
`endif

  assign step = (cnt_q == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_SHIFT;
      dir_q  <= DIR_LEFT;
      pat_q  <= RESET_PAT;
      cnt_q  <= '0;
      leds_q <= RESET_LEDS;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      leds_q <= (LED_ACTIVE_LOW != 0) ? ~pat_q : pat_q;
    end
  end

  // A press restarts the new mode from its init pattern and discards a coincident step.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    if (mode_press) begin
      mode_d = mode_next(mode_q);
      pat_d  = LED_W'(mode_init(mode_d));
      dir_d  = DIR_LEFT;
      cnt_d  = '0;
    end else if (run) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
      if (step) begin
        case (mode_q)
          MODE_BOUNCE: begin
            pat_d = (dir_q == DIR_LEFT) ? (pat_q << 1) : (pat_q >> 1);
            // Flip on arrival at an end so each endpoint is shown for a single step.
            if (pat_d[LED_W-1])  dir_d = DIR_RIGHT;
            else if (pat_d[0])   dir_d = DIR_LEFT;
          end
          MODE_BINARY: pat_d = pat_q + 1'b1;
          default:     pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        endcase
      end
    end
  end

  assign bus.leds         = leds_q;
  assign bus.clockCounter = cnt_q;
  assign bus.mode         = mode_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb/tb_led_pattern_seq.sv - self-checking bench for led_pattern_seq (directed table, random stimulus, reference model)
module tb_led_pattern_seq;
  localparam int STEP  = 4;
  localparam int DEB   = 3;
  localparam int CNT_W = 24;
  localparam int LED_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_pattern_seq_if #(.LED_W(LED_W), .CNT_W(CNT_W)) bif ();

  led_pattern_seq #(
    .STEP_TICKS(STEP), .DEBOUNCE_TICKS(DEB), .CNT_W(CNT_W), .LED_W(LED_W), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: time since last mode change (m_t) determines everything.
  int               m_mode, m_t;
  bit               m_paused, m_press_pend, m_pause_pend, m_lvl, m_lvl2;
  bit               hist[$], hist2[$];
  logic [LED_W-1:0] m_leds;

  function automatic logic [LED_W-1:0] pattern_of(input int mode, input int k);
    int per, p;
    per = 2 * (LED_W - 1);
    case (mode)
      1: begin
        p = k % per;
        if (p > LED_W - 1) p = per - p;
        return LED_W'(1) << p;
      end
      2:       return LED_W'(k % (1 << LED_W));
      default: return LED_W'(1) << (k % LED_W);
    endcase
  endfunction

  // Button accepted when the last DEB synchronized samples (2 edges old) all differ from the level.
  function automatic bit accept(input bit q[$], input bit lvl);
    for (int i = 0; i < DEB; i++)
      if (q[q.size() - 3 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_t = 0; m_paused = 0;
    m_press_pend = 0; m_pause_pend = 0; m_lvl = 1; m_lvl2 = 1;
    hist.delete(); hist2.delete();
    for (int i = 0; i < DEB + 2; i++) begin
      hist.push_back(1'b1);
      hist2.push_back(1'b1);
    end
    m_leds = ~pattern_of(0, 0);
  endtask

  task automatic model_edge(input bit b, input bit b2);
    m_leds = ~pattern_of(m_mode, m_t / STEP);
    if (m_press_pend) begin
      m_mode = (m_mode + 1) % 3;
      m_t = 0;
    end else if (!m_paused) begin
      m_t++;
    end
    if (m_pause_pend) m_paused = !m_paused;
    hist.push_back(b);
    if (hist.size() > DEB + 6) void'(hist.pop_front());
    m_press_pend = 0;
    if (accept(hist, m_lvl)) begin
      m_lvl = !m_lvl;
      m_press_pend = !m_lvl;
    end
`ifdef LED_PAUSE_EN
    hist2.push_back(b2);
    if (hist2.size() > DEB + 6) void'(hist2.pop_front());
    m_pause_pend = 0;
    if (accept(hist2, m_lvl2)) begin
      m_lvl2 = !m_lvl2;
      m_pause_pend = !m_lvl2;
    end
`else
    m_pause_pend = b2 & 1'b0;
`endif
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_cnt", int'(bif.clockCounter), m_t % STEP);
    check("model_mode", int'(bif.mode), m_mode);
    check("model_leds", int'(bif.leds), int'(m_leds));
  endtask

  task automatic tick(input bit r, input bit b, input bit b2);
    rst = r;
    bif.btn_n = b;
`ifdef LED_PAUSE_EN
    bif.btn2_n = b2;
`endif
    if (r) m_reset();
    @(posedge clk);
    if (r) m_reset();
    else   model_edge(b, b2);
    #1;
    check_model();
  endtask

  typedef struct {
    bit               r;
    bit               b;
    int               n;
    int               e_mode;
    int               e_cnt;
    logic [LED_W-1:0] e_leds;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1'b1, 1'b1,   5, 0, 0, 6'b111110};  // reset
    vt[1]  = '{1'b0, 1'b1,  28, 0, 0, 6'b111110};  // 7 SHIFT steps, rotate wrap
    vt[2]  = '{1'b0, 1'b0,   2, 0, 2, 6'b111101};  // short glitch
    vt[3]  = '{1'b0, 1'b1,   5, 0, 3, 6'b111011};
    vt[4]  = '{1'b0, 1'b0,  10, 1, 0, 6'b111110};  // one press -> BOUNCE
    vt[5]  = '{1'b0, 1'b0, 100, 1, 0, 6'b011111};  // held: no further press
    vt[6]  = '{1'b0, 1'b1,  10, 1, 2, 6'b111011};
    vt[7]  = '{1'b0, 1'b0,  10, 2, 0, 6'b111111};  // -> BINARY
    vt[8]  = '{1'b0, 1'b1, 262, 2, 2, 6'b111101};  // past 111111 -> 000000
    vt[9]  = '{1'b0, 1'b0,   6, 0, 0, 6'b111100};  // press lands on step cycle
    vt[10] = '{1'b0, 1'b0,   1, 0, 1, 6'b111110};  // no extra step taken
    vt[11] = '{1'b0, 1'b1,  10, 0, 3, 6'b111011};
    vt[12] = '{1'b0, 1'b0,  10, 1, 0, 6'b111110};
    vt[13] = '{1'b0, 1'b0,   5, 1, 1, 6'b111011};
    vt[14] = '{1'b1, 1'b0,   3, 0, 0, 6'b111110};  // reset mid-op, button held
    vt[15] = '{1'b0, 1'b1,  20, 0, 0, 6'b101111};

    bif.btn_n = 1'b1;
`ifdef LED_PAUSE_EN
    bif.btn2_n = 1'b1;
`endif
    m_reset();

    for (int v = 0; v < 16; v++) begin
      for (int c = 0; c < vt[v].n; c++) tick(vt[v].r, vt[v].b, 1'b1);
      check($sformatf("vec%0d_mode", v), int'(bif.mode), vt[v].e_mode);
      check($sformatf("vec%0d_cnt", v), int'(bif.clockCounter), vt[v].e_cnt);
      check($sformatf("vec%0d_leds", v), int'(bif.leds), int'(vt[v].e_leds));
    end

    // Counter sequence straight after reset release.
    tick(1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick(1'b0, 1'b1, 1'b1);
      check("post_reset_cnt", int'(bif.clockCounter), c % STEP);
    end

`ifdef LED_PAUSE_EN
    begin
      int frozen;
      for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, 1'b0);
      frozen = m_t % STEP;
      for (int c = 0; c < 20; c++) begin
        tick(1'b0, 1'b1, 1'b1);
        check("paused_cnt", int'(bif.clockCounter), frozen);
      end
      for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, 1'b1);
      check("resumed", int'(m_paused), 0);
    end
`endif

    for (int s = 0; s < 150; s++) begin
      bit r, b, b2;
      int len;
      r   = ($urandom_range(0, 39) == 0);
      b   = $urandom_range(0, 1);
      b2  = $urandom_range(0, 3) != 0;
      len = r ? 2 : $urandom_range(1, 12);
      for (int c = 0; c < len; c++) tick(r, b, b2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
